// File: rtl/color_slew.sv
// Per-frame colour slew limiter: latches band colours on FFT-done and walks the displayed word
// toward them one bounded step per update. Define COLOR_SLEW_SNAP_EN to jump straight to the target.
module color_slew #(
  parameter int NUM_BANDS = 7,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [12*NUM_BANDS-1:0]   color_in,
  input  logic                      color_valid,
  input  logic                      freeze,
  input  logic                      vsync,
  output logic [12*NUM_BANDS-1:0]   color_out,
  output logic                      update_done,
  output logic                      busy
);

  localparam int W = 12 * NUM_BANDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_COMMIT
  } state_t;

  state_t         state_q, state_d;
  logic           vsync_q, vsync_prev_q;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [W-1:0]   target_q, target_d;
  logic [W-1:0]   pending_q, pending_d;
  logic           pend_vld_q, pend_vld_d;
  logic [W-1:0]   color_out_q, color_out_d;
  logic           update_done_q, update_done_d;

  logic           tick;
  logic           upd_req;
  logic           capture;

  // A tick is a 1->0 transition between two registered vsync samples.
  assign tick    = vsync_prev_q & ~vsync_q;
  assign capture = color_valid & ~freeze;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    upd_req     = 1'b0;
    if (tick) begin
      if (frame_cnt_q == 8'(FRAME_DIV - 1)) begin
        frame_cnt_d = 8'd0;
        upd_req     = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

`ifndef COLOR_SLEW_SNAP_EN
  localparam int N  = 3 * NUM_BANDS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(W);

  logic [W-1:0]   working_q, working_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [BW-1:0]  base;
  logic [3:0]     cur_nib, tgt_nib, new_nib, diff;

  assign base    = BW'({idx_q, 2'b00});
  assign cur_nib = working_q[base +: 4];
  assign tgt_nib = target_q[base +: 4];

  // Step limited so the nibble lands exactly on the target rather than overshooting.
  always_comb begin
    new_nib = cur_nib;
    diff    = 4'd0;
    if (cur_nib < tgt_nib) begin
      diff    = tgt_nib - cur_nib;
      new_nib = (diff > 4'(STEP)) ? cur_nib + 4'(STEP) : tgt_nib;
    end else if (cur_nib > tgt_nib) begin
      diff    = cur_nib - tgt_nib;
      new_nib = (diff > 4'(STEP)) ? cur_nib - 4'(STEP) : tgt_nib;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    pending_d     = pending_q;
    pend_vld_d    = pend_vld_q;
    color_out_d   = color_out_q;
    update_done_d = 1'b0;
`ifndef COLOR_SLEW_SNAP_EN
    working_d     = working_q;
    idx_d         = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (capture) target_d = color_in;
        if (upd_req) begin
`ifdef COLOR_SLEW_SNAP_EN
          state_d   = S_COMMIT;
`else
          working_d = color_out_q;
          idx_d     = '0;
          state_d   = S_STEP;
`endif
        end
      end
      S_STEP: begin
`ifndef COLOR_SLEW_SNAP_EN
        working_d[base +: 4] = new_nib;
        if (idx_q == IW'(N - 1)) state_d = S_COMMIT;
        else                     idx_d   = idx_q + 1'b1;
`else
        state_d = S_IDLE;
`endif
        if (capture) begin
          pending_d  = color_in;
          pend_vld_d = 1'b1;
        end
      end
      S_COMMIT: begin
`ifdef COLOR_SLEW_SNAP_EN
        color_out_d   = target_q;
`else
        color_out_d   = working_q;
`endif
        update_done_d = 1'b1;
        state_d       = S_IDLE;
        // A pulse arriving in this very cycle is newer than anything pending.
        if (capture) begin
          target_d   = color_in;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          target_d   = pending_q;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b1;
      vsync_prev_q  <= 1'b1;
      frame_cnt_q   <= 8'd0;
      target_q      <= '0;
      pending_q     <= '0;
      pend_vld_q    <= 1'b0;
      color_out_q   <= '0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      vsync_prev_q  <= vsync_q;
      frame_cnt_q   <= frame_cnt_d;
      target_q      <= target_d;
      pending_q     <= pending_d;
      pend_vld_q    <= pend_vld_d;
      color_out_q   <= color_out_d;
      update_done_q <= update_done_d;
    end
  end

`ifndef COLOR_SLEW_SNAP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      working_q <= '0;
      idx_q     <= '0;
    end else begin
      working_q <= working_d;
      idx_q     <= idx_d;
    end
  end
`endif

  assign color_out   = color_out_q;
  assign update_done = update_done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_color_slew.sv
// Directed bench for color_slew: three instances (STEP=1/FD=1, STEP=4/FD=1, STEP=1/FD=3)
// exercised one at a time; expectations follow COLOR_SLEW_SNAP_EN when it is defined.
module tb_color_slew;
  localparam int W = 84;
`ifdef COLOR_SLEW_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  localparam int LAT  = SNAP ? 3 : 24;
  localparam int BUSY = SNAP ? 1 : 22;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [W-1:0] color_in;
  logic         freeze;
  logic [2:0]   valid_v, vsync_v, ud_v, busy_v;
  logic [W-1:0] out_a, out_b, out_c;

  color_slew #(.NUM_BANDS(7), .STEP(1), .FRAME_DIV(1)) u_a (
    .clock(clock), .reset(reset), .color_in(color_in), .color_valid(valid_v[0]),
    .freeze(freeze), .vsync(vsync_v[0]), .color_out(out_a), .update_done(ud_v[0]), .busy(busy_v[0]));
  color_slew #(.NUM_BANDS(7), .STEP(4), .FRAME_DIV(1)) u_b (
    .clock(clock), .reset(reset), .color_in(color_in), .color_valid(valid_v[1]),
    .freeze(freeze), .vsync(vsync_v[1]), .color_out(out_b), .update_done(ud_v[1]), .busy(busy_v[1]));
  color_slew #(.NUM_BANDS(7), .STEP(1), .FRAME_DIV(3)) u_c (
    .clock(clock), .reset(reset), .color_in(color_in), .color_valid(valid_v[2]),
    .freeze(freeze), .vsync(vsync_v[2]), .color_out(out_c), .update_done(ud_v[2]), .busy(busy_v[2]));

  int n_checks = 0;
  int n_fail   = 0;
  int lat_r, busy_r, ud_r;
  int ud_tot;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ex(input logic [W-1:0] slew_v, input logic [W-1:0] snap_v);
    return SNAP ? snap_v : slew_v;
  endfunction

  function automatic logic [W-1:0] out_of(input int i);
    case (i)
      0:       return out_a;
      1:       return out_b;
      default: return out_c;
    endcase
  endfunction

  task automatic load(input int inst, input logic [W-1:0] word);
    @(posedge clock); #1;
    color_in      = word;
    valid_v[inst] = 1'b1;
    @(posedge clock); #1;
    valid_v[inst] = 1'b0;
  endtask

  // One vsync fall, then 50 observed cycles; optional colour pulses at cycle v1_at / v2_at
  // and an optional second vsync fall at refall_at.
  task automatic tick(input int inst, input int v1_at, input logic [W-1:0] v1_w,
                      input int v2_at, input logic [W-1:0] v2_w, input int refall_at);
    lat_r = -1; busy_r = 0; ud_r = 0;
    @(posedge clock); #1;
    vsync_v[inst] = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clock); #1;
      if (ud_v[inst]) begin
        ud_r++;
        if (lat_r < 0) lat_r = n;
      end
      if (busy_v[inst]) busy_r++;
      valid_v[inst] = 1'b0;
      if (n == v1_at) begin color_in = v1_w; valid_v[inst] = 1'b1; end
      if (n == v2_at) begin color_in = v2_w; valid_v[inst] = 1'b1; end
      if (n == 3 || n == refall_at + 3) vsync_v[inst] = 1'b1;
      if (n == refall_at) vsync_v[inst] = 1'b0;
    end
    valid_v[inst] = 1'b0;
    vsync_v[inst] = 1'b1;
    $display("tick inst=%0d out=%h lat=%0d busy=%0d ud=%0d", inst, out_of(inst), lat_r, busy_r, ud_r);
  endtask

  initial begin
    reset    = 1'b0;
    color_in = '1;
    freeze   = 1'b0;
    valid_v  = 3'b000;
    vsync_v  = 3'b111;

    // Reset held: activity on inputs must not disturb outputs
    repeat (2) @(posedge clock);
    #1; valid_v = 3'b111; vsync_v = 3'b000;
    @(posedge clock); #1; valid_v = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_out_c", out_c, '0);
    chk_i("rst_busy", int'(busy_v), 0);
    chk_i("rst_ud", int'(ud_v), 0);
    vsync_v = 3'b111;
    @(posedge clock); #1;
    reset = 1'b1;

    // Empty target: update happens but colours stay zero
    tick(0, -1, '0, -1, '0, 0);
    chk("a_zero_out", out_a, '0);
    chk_i("a_zero_lat", lat_r, LAT);
    chk_i("a_zero_busy", busy_r, BUSY);
    chk_i("a_zero_ud", ud_r, 1);

    // Single step, STEP=1
    load(0, {7{12'h00F}});
    tick(0, -1, '0, -1, '0, 0);
    chk("a_step1", out_a, ex({7{12'h001}}, {7{12'h00F}}));
    chk_i("a_step1_lat", lat_r, LAT);
    chk_i("a_step1_busy", busy_r, BUSY);
    tick(0, -1, '0, -1, '0, 0);
    chk("a_step2", out_a, ex({7{12'h002}}, {7{12'h00F}}));
    tick(0, -1, '0, -1, '0, 0);
    chk("a_step3", out_a, ex({7{12'h003}}, {7{12'h00F}}));
    chk_i("a_step3_lat", lat_r, LAT);

    // Pending capture mid-STEP
    tick(0, 5, {7{12'h0F0}}, -1, '0, 0);
    chk("a_pend_cur", out_a, ex({7{12'h004}}, {7{12'h00F}}));
    tick(0, -1, '0, -1, '0, 0);
    chk("a_pend_next", out_a, ex({7{12'h013}}, {7{12'h0F0}}));

    // Freeze blocks capture but not slewing
    freeze = 1'b1;
    load(0, {7{12'hF00}});
    tick(0, 5, {7{12'hF00}}, -1, '0, 0);
    chk("a_frz1", out_a, ex({7{12'h022}}, {7{12'h0F0}}));
    freeze = 1'b0;
    tick(0, -1, '0, -1, '0, 0);
    chk("a_frz2", out_a, ex({7{12'h031}}, {7{12'h0F0}}));

    // Second tick while busy is dropped
    tick(0, -1, '0, -1, '0, 8);
    chk_i("a_drop_ud", ud_r, SNAP ? 2 : 1);
    chk("a_drop_out", out_a, ex({7{12'h040}}, {7{12'h0F0}}));

    // Pulse in COMMIT cycle beats the pending word
    tick(0, 5, {7{12'h00F}}, 23, {7{12'hF00}}, 0);
    chk("a_cmt_cur", out_a, ex({7{12'h050}}, {7{12'h0F0}}));
    tick(0, -1, '0, -1, '0, 0);
    chk("a_cmt_next", out_a, ex({7{12'h140}}, {7{12'hF00}}));

    // STEP=4: saturation and decrement
    load(1, {7{12'h00E}});
    tick(1, -1, '0, -1, '0, 0);
    chk("b_s1", out_b, ex({7{12'h004}}, {7{12'h00E}}));
    tick(1, -1, '0, -1, '0, 0);
    chk("b_s2", out_b, ex({7{12'h008}}, {7{12'h00E}}));
    tick(1, -1, '0, -1, '0, 0);
    chk("b_s3", out_b, ex({7{12'h00C}}, {7{12'h00E}}));
    tick(1, -1, '0, -1, '0, 0);
    chk("b_s4", out_b, ex({7{12'h00E}}, {7{12'h00E}}));
    load(1, {7{12'h00F}});
    tick(1, -1, '0, -1, '0, 0);
    chk("b_sat", out_b, ex({7{12'h00F}}, {7{12'h00F}}));
    load(1, '0);
    tick(1, -1, '0, -1, '0, 0);
    chk("b_dec", out_b, ex({7{12'h00B}}, '0));

    // Per-band packing
    load(1, {{4{12'h00B}}, 12'h0A9, 12'hF0B, 12'h123});
    tick(1, -1, '0, -1, '0, 0);
    chk("b_pack", out_b, ex({{4{12'h00B}}, 12'h049, 12'h40B, 12'h127},
                            {{4{12'h00B}}, 12'h0A9, 12'hF0B, 12'h123}));

    // FRAME_DIV=3: six ticks, two updates
    load(2, {7{12'h00F}});
    ud_tot = 0;
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    chk_i("c_div_early", ud_tot, 0);
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    chk_i("c_div_lat", lat_r, LAT);
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    tick(2, -1, '0, -1, '0, 0); ud_tot += ud_r;
    chk_i("c_div_total", ud_tot, 2);
    chk("c_div_out", out_c, ex({7{12'h002}}, {7{12'h00F}}));

    // Reset mid-update
    @(posedge clock); #1;
    vsync_v[0] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    vsync_v[0] = 1'b1;
    chk_i("a_mid_busy_pre", int'(busy_v[0]), SNAP ? 0 : 1);
    reset = 1'b0;
    #1;
    chk("a_mid_out", out_a, '0);
    chk("b_mid_out", out_b, '0);
    chk_i("a_mid_busy", int'(busy_v[0]), 0);
    repeat (3) @(posedge clock);
    #1;
    chk_i("a_mid_ud", int'(ud_v), 0);
    reset = 1'b1;
    tick(0, -1, '0, -1, '0, 0);
    chk("a_post_rst", out_a, '0);
    chk_i("a_post_rst_lat", lat_r, LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/color_slew.md
# color_slew

Per-frame colour slew limiter between the FFT band-energy stage and the VGA colour output stage. It latches the 84-bit packed band colour word (7 bands × 12-bit RGB) on each FFT-done pulse and walks a displayed copy toward it by a bounded step once per video frame. The displayed word is committed atomically at the frame boundary, which removes tearing and strobing when the band energies jump between FFT frames.

## Interface
- `NUM_BANDS`, 7: bands in the packed word; word width is 12·NUM_BANDS.
- `STEP`, 1: maximum change per 4-bit channel per update, legal range 1..15.
- `FRAME_DIV`, 1: perform one update every FRAME_DIV vsync ticks, legal range 1..255.
- `clock`  in  1  video clock. All inputs are synchronous to it.
- `reset`  in  1  asynchronous, active-low. 0 = reset.
- `color_in`  in  84  target colours. Band k occupies [12k+11:12k], ordered R[11:8], G[7:4], B[3:0].
- `color_valid`  in  1  single-cycle pulse; `color_in` is valid in that cycle.
- `freeze`  in  1  while 1, `color_valid` is ignored. Driven from the offset-adjust mode.
- `vsync`  in  1  VGA vsync, active-low.
- `color_out`  out  84  displayed colours, same packing as `color_in`.
- `update_done`  out  1  single-cycle pulse in the cycle `color_out` changes.
- `busy`  out  1  1 while the state machine is out of IDLE.

## Operation
- Reset state:
  - `color_out` = 0, `update_done` = 0, `busy` = 0.
  - Target, pending and working registers = 0; pending flag = 0.
  - Frame counter = 0; FSM = IDLE; vsync history register = 1.
- Frame tick: `vsync` sampled 0 in a cycle where the previous sample was 1.
- Frame counter:
  - Increments on each tick.
  - When it reaches FRAME_DIV−1 and a tick arrives, it wraps to 0 and raises an update request.
- Target capture, when `color_valid`=1 and `freeze`=0:
  - FSM in IDLE: target ← `color_in`.
  - FSM not in IDLE: pending ← `color_in` and pending flag ← 1.
  - A later pulse overwrites the pending register. Last value wins.
- FSM states:
  - IDLE: on an update request, working ← `color_out`, index ← 0, go to STEP.
  - STEP: one nibble per cycle, at index 0..20 (20 = band 6 R). Per nibble:
    - cur < tgt: cur + min(STEP, tgt−cur).
    - cur > tgt: cur − min(STEP, cur−tgt).
    - The result never overshoots and never wraps.
    - After index 20, go to COMMIT.
  - COMMIT: `color_out` ← working and `update_done` = 1.
    - If the pending flag is set: target ← pending, flag ← 0.
    - Go to IDLE.
- A frame tick while not in IDLE still advances the frame counter. An update request raised then is dropped, not queued.
- A `color_valid` pulse in the same cycle as COMMIT goes to pending. That new value is then lost to the COMMIT transfer, so COMMIT gives priority to the incoming pulse: target ← `color_in` and the pending flag is cleared.
- `freeze` does not stop slewing toward the already-latched target.
- Reset asserted mid-update: everything returns to reset values immediately. No partial word ever reaches `color_out`.

## Timing
- Tick is recognised in the cycle after `vsync` is first sampled low.
- IDLE→STEP on the following edge. STEP takes 21 cycles. COMMIT follows.
- `color_out` changes 23 cycles after the first low `vsync` sample, in the same cycle as `update_done`.
- `busy` = 1 for 22 cycles per update (21 STEP + 1 COMMIT).
- `color_out` is stable between `update_done` pulses.
- Worst-case convergence: ceil(15/STEP) updates.

## Configuration
- `COLOR_SLEW_SNAP_EN`
  - Defined: STEP logic is compiled out. The FSM goes IDLE→COMMIT directly and `color_out` ← target, so latency from tick to `update_done` is 2 cycles. `busy` = 1 for 1 cycle.
  - Undefined: bounded slewing as described above.

## Test plan
- Reset: hold `reset`=0 with `color_in`=all F and `color_valid` pulsed → `color_out`=0, `busy`=0, no `update_done`.
- Single step, STEP=1, FRAME_DIV=1: load target 0x00F repeated ×7, then 3 frame ticks → `color_out` B nibbles 1, 2, 3. `update_done` 23 cycles after each vsync fall.
- Saturation, STEP=4: `color_out` band0=0x00E, target band0=0x00F → B=0xF after one update, not 0x2.
- Pending: pulse `color_valid` with 0x0F0 mid-STEP → current update slews toward the old target; the next update moves G toward 0xF.
- Freeze: `freeze`=1 with `color_valid` carrying 0xF00 → target unchanged; existing slew continues.
- FRAME_DIV=3: 6 ticks → exactly 2 `update_done` pulses. Same stimulus with `COLOR_SLEW_SNAP_EN` → `color_out` equals the target after the first update.
